timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_pkg.sv | 14 +
 rtl/timer_ctrl_counter.sv | 31 +++
 rtl/timer_ctrl.sv | 121 ++++++++++++
 tb/tb_timer_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer controller and its counter datapath.
package timer_ctrl_pkg;
  localparam int   DEF_WIDTH     = 4;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/timer_ctrl_counter.sv
// Counting datapath: clear / hold / increment register with a terminal compare.
// Knows nothing about modes or interrupts; the controller decides when to step.
module tc_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hold,
  input  logic             en,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             at_term
);
  logic [WIDTH-1:0] count_q, count_d;

  // clear beats hold, hold beats enable
  always_comb begin
    count_d = count_q;
    if (clr)             count_d = '0;
    else if (en && !hold) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count   = count_q;
  assign at_term = (count_q == term_val);
endmodule

// File: rtl/timer_ctrl.sv
// One-shot / periodic timer with pause/resume, sticky interrupt and overrun flag.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             irq,
  input  logic             irq_ack,
  output logic             overrun
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             irq_q, irq_d;
  logic             overrun_q, overrun_d;
  logic             cnt_clr, cnt_hold, cnt_en, at_term, term_evt, accept;

  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_ARMED) || (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign accept    = cfg_valid && cfg_ready;
  assign cnt_hold  = (state_q != ST_RUN);

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    mode_d    = mode_q;
    irq_d     = irq_q;
    overrun_d = overrun_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    term_evt  = 1'b0;

    unique case (state_q)
      ST_IDLE: ;
      ST_ARMED, ST_DONE: begin
        // stop outranks start, and stop alone does nothing here
        if (start && !stop) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (at_term) begin
          term_evt = 1'b1;
          if (mode_q == MODE_PERIODIC) cnt_clr = 1'b1;
          else                         state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_ARMED;
          cnt_clr = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a terminal event coinciding with irq_ack keeps irq set and is not an overrun
    if (term_evt) begin
      irq_d = 1'b1;
      if (irq_q && !irq_ack) overrun_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end

    // accepted configuration only happens outside RUN, so it never races a terminal event
    if (accept) begin
      period_d  = cfg_period;
      mode_d    = cfg_mode;
      overrun_d = 1'b0;
      cnt_clr   = 1'b1;
      state_d   = ST_ARMED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      mode_q    <= MODE_ONESHOT;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
    end
  end

  tc_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (cnt_clr),
    .hold    (cnt_hold),
    .en      (cnt_en),
    .term_val(period_q),
    .count   (count),
    .at_term (at_term)
  );

  assign irq     = irq_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed scenarios plus random traffic, checked against a behavioural timer model.
module tb_timer_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid, cfg_mode, start, stop, irq_ack;
  logic [W-1:0] cfg_period;
  logic         cfg_ready, busy, irq, overrun;
  logic [W-1:0] count;

  int passed = 0;
  int total  = 0;

  // model: phase 0 idle, 1 armed, 2 running, 3 paused, 4 done
  int   m_ph, m_cnt, m_per;
  logic m_per_mode, m_irq, m_ov;
  string tag;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .count     (count),
    .busy      (busy),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_per = 0; m_per_mode = 1'b0; m_irq = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_edge();
    bit term;
    bit can_cfg;
    term    = 0;
    can_cfg = (m_ph == 0 || m_ph == 1 || m_ph == 4);
    if (can_cfg && cfg_valid) begin
      m_per = cfg_period; m_per_mode = cfg_mode; m_ov = 1'b0; m_cnt = 0; m_ph = 1;
    end else if (m_ph == 1 || m_ph == 4) begin
      if (start && !stop) begin m_ph = 2; m_cnt = 0; end
    end else if (m_ph == 2) begin
      if (stop) m_ph = 3;
      else if (m_cnt == m_per) begin
        term = 1;
        if (m_per_mode) m_cnt = 0;
        else            m_ph = 4;
      end else m_cnt = m_cnt + 1;
    end else if (m_ph == 3) begin
      if (stop) begin m_ph = 1; m_cnt = 0; end
      else if (start) m_ph = 2;
    end
    if (term) begin
      if (m_irq && !irq_ack) m_ov = 1'b1;
      m_irq = 1'b1;
    end else if (irq_ack) m_irq = 1'b0;
  endtask

  task automatic check_all();
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".busy"}, int'(busy), int'(m_ph == 2 || m_ph == 3));
    chk({tag, ".cfg_ready"}, int'(cfg_ready), int'(m_ph == 0 || m_ph == 1 || m_ph == 4));
    chk({tag, ".irq"}, int'(irq), int'(m_irq));
    chk({tag, ".overrun"}, int'(overrun), int'(m_ov));
  endtask

  task automatic step(input logic cv, input logic [W-1:0] cp, input logic cm,
                      input logic st, input logic sp, input logic ack);
    cfg_valid = cv; cfg_period = cp; cfg_mode = cm; start = st; stop = sp; irq_ack = ack;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0; cfg_valid = 0; cfg_period = 0; cfg_mode = 0; start = 0; stop = 0; irq_ack = 0;
    model_reset();
    #3;
    tag = "reset"; check_all();
    #9 reset = 1'b1;

    tag = "idle_start";
    step(0, 0, 0, 1, 0, 0);
    chk("idle_start_ignored", int'(busy), 0);

    // P=5 periodic
    tag = "s46";
    step(1, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("s46_seq", int'(count), k);
    end
    chk("s46_irq_low", int'(irq), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("s46_irq_rise", int'(irq), 1);
    chk("s46_wrap", int'(count), 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // P=3 one-shot
    tag = "s47";
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(3);
    chk("s47_cnt3", int'(count), 3);
    step(0, 0, 0, 0, 0, 0);
    chk("s47_irq", int'(irq), 1);
    chk("s47_busy", int'(busy), 0);
    step(0, 0, 0, 0, 1, 0);
    idle(2);
    chk("s47_hold", int'(count), 3);
    step(0, 0, 0, 0, 0, 1);
    chk("s47_ack", int'(irq), 0);

    // P=7 periodic, three held edges around a pause
    tag = "s48";
    step(1, 7, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(4);
    step(0, 0, 0, 0, 1, 0);
    chk("s48_pause", int'(count), 4);
    idle(1);
    step(0, 0, 0, 1, 0, 0);
    chk("s48_resume_hold", int'(count), 4);
    step(0, 0, 0, 0, 0, 0);
    chk("s48_resume5", int'(count), 5);
    idle(2);
    chk("s48_irq_not_yet", int'(irq), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("s48_irq_delayed", int'(irq), 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);

    // P=1 periodic, no ack -> overrun
    tag = "s49";
    step(1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    chk("s49_first_irq", int'(irq), 1);
    chk("s49_no_ov_yet", int'(overrun), 0);
    idle(2);
    chk("s49_overrun", int'(overrun), 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("s49_ov_sticky", int'(overrun), 1);
    step(1, 2, 1, 0, 0, 0);
    chk("s49_ov_cleared", int'(overrun), 0);
    step(0, 0, 0, 0, 0, 1);

    // cfg during RUN ignored; start+stop -> pause
    tag = "s50";
    step(1, 5, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    step(1, 9, 0, 0, 0, 0);
    chk("s50_not_ready", int'(cfg_ready), 0);
    idle(2);
    chk("s50_at5", int'(count), 5);
    step(0, 0, 0, 0, 0, 0);
    chk("s50_period_kept", int'(count), 0);
    chk("s50_irq", int'(irq), 1);
    step(0, 0, 0, 1, 1, 1);
    chk("s50_stop_wins", int'(busy), 1);
    idle(1);
    chk("s50_paused_hold", int'(count), 0);
    step(0, 0, 0, 0, 1, 0);

    // P=0 corner cases
    tag = "p0";
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(3);
    chk("p0_periodic_cnt", int'(count), 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("p0_oneshot_done", int'(busy), 0);
    step(0, 0, 0, 0, 0, 1);

    // asynchronous reset mid-run
    tag = "s51";
    step(1, 15, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("s51_async_cnt", int'(count), 0);
    #10 reset = 1'b1;
    step(0, 0, 0, 1, 0, 0);
    chk("s51_idle_after", int'(busy), 0);

    // random traffic
    tag = "rnd";
    for (int i = 0; i < 400; i++)
      step(($urandom % 8) == 0, W'($urandom), 1'($urandom), ($urandom % 3) == 0,
           ($urandom % 7) == 0, ($urandom % 4) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
